// File: rtl/uart_pkg.sv
// Shared definitions for the Wishbone UART transmitter: register offsets,
// STATUS bit positions, transmit FSM states and 8N1 line levels.
package uart_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_IE    = 3;
  localparam int STAT_OVF   = 4;

  localparam int   FRAME_DATA_BITS = 8;
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  function automatic logic [7:0] pack_status(input logic busy, input logic full,
                                             input logic empty, input logic ie,
                                             input logic ovf);
    logic [7:0] s;
    s             = 8'h00;
    s[STAT_BUSY]  = busy;
    s[STAT_FULL]  = full;
    s[STAT_EMPTY] = empty;
    s[STAT_IE]    = ie;
    s[STAT_OVF]   = ovf;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO holding bytes waiting for the transmitter.
// Head word is visible combinationally so the FSM can load it on the pop edge.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is dropped even if a pop happens on the same edge.
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign full     = (count_reg == CNT_W'(DEPTH));
  assign empty    = (count_reg == '0);
  assign pop_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone-slave 8N1 UART transmitter: register decode, FIFO front end,
// baud/bit counters and the serialiser FSM, plus a drained-path interrupt.
module wb_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       PClk,
  input  logic       Reset,
  input  logic [6:2] ADR_WB,
  input  logic [7:0] DAT_WB,
  input  logic       WE_WB,
  input  logic       STB_UTX,
  output logic       ACK_UTX,
  output logic [7:0] DAT_UTX,
  output logic       TxD,
  output logic       IntTx
);

  localparam int                BAUD_W      = $clog2(CLK_DIV);
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);
  localparam logic [2:0]        LAST_BIT    = 3'(FRAME_DATA_BITS - 1);

  // Bus-side state
  logic       ack_reg;
  logic [7:0] rd_data_reg;
  logic       ie_reg;
  logic       ovf_reg;
  logic       int_reg;

  logic       access;
  logic [1:0] reg_sel;
  logic       push_req;
  logic [7:0] status_value;
  logic [7:0] rd_value;
  logic       unused_adr;

  // Transmit path
  tx_state_t         state_reg, state_next;
  logic [BAUD_W-1:0] baud_reg, baud_next;
  logic [2:0]        bit_reg, bit_next;
  logic [7:0]        shift_reg, shift_next;
  logic              tx_reg, tx_next;

  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_data;

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (PClk),
    .srst      (Reset),
    .push      (push_req),
    .push_data (DAT_WB),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A strobe held through its own acknowledge is not a new access.
  assign access     = STB_UTX & ~ack_reg;
  assign reg_sel    = ADR_WB[3:2];
  assign push_req   = access & WE_WB & (reg_sel == REG_TXDATA);
  assign unused_adr = ^ADR_WB[6:4];

  assign status_value = pack_status(state_reg != TX_IDLE, fifo_full, fifo_empty,
                                    ie_reg, ovf_reg);

  always_comb begin
    rd_value = 8'h00;
    case (reg_sel)
      REG_STATUS: rd_value = status_value;
      REG_CTRL:   rd_value = {7'b0, ie_reg};
      default:    rd_value = 8'h00;
    endcase
  end

  always_ff @(posedge PClk) begin
    if (Reset) begin
      ack_reg     <= 1'b0;
      rd_data_reg <= 8'h00;
      ie_reg      <= 1'b0;
      ovf_reg     <= 1'b0;
      int_reg     <= 1'b0;
    end else begin
      ack_reg     <= access;
      rd_data_reg <= (access & ~WE_WB) ? rd_value : 8'h00;
      if (access & WE_WB & (reg_sel == REG_CTRL)) begin
        ie_reg <= DAT_WB[0];
      end
      if (push_req & fifo_full) begin
        ovf_reg <= 1'b1;
      end else if (access & ~WE_WB & (reg_sel == REG_STATUS)) begin
        ovf_reg <= 1'b0;
      end
      int_reg <= ie_reg & fifo_empty & (state_reg == TX_IDLE);
    end
  end

  always_ff @(posedge PClk) begin
    if (Reset) begin
      state_reg <= TX_IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= LINE_IDLE;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    fifo_pop   = 1'b0;
    case (state_reg)
      TX_IDLE: begin
        baud_next = '0;
        bit_next  = '0;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_next = fifo_data;
          state_next = TX_START;
          baud_next  = BAUD_RELOAD;
        end
      end
      TX_START: begin
        if (baud_reg == '0) begin
          state_next = TX_DATA;
          baud_next  = BAUD_RELOAD;
          bit_next   = '0;
        end else begin
          baud_next = baud_reg - BAUD_W'(1);
        end
      end
      TX_DATA: begin
        if (baud_reg == '0) begin
          baud_next  = BAUD_RELOAD;
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_reg == LAST_BIT) begin
            state_next = TX_STOP;
          end else begin
            bit_next = bit_reg + 3'(1);
          end
        end else begin
          baud_next = baud_reg - BAUD_W'(1);
        end
      end
      TX_STOP: begin
        if (baud_reg == '0) begin
          // Chain straight into the next start bit so frames stay contiguous.
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shift_next = fifo_data;
            state_next = TX_START;
            baud_next  = BAUD_RELOAD;
          end else begin
            state_next = TX_IDLE;
            baud_next  = '0;
          end
        end else begin
          baud_next = baud_reg - BAUD_W'(1);
        end
      end
      default: state_next = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_next = LINE_IDLE;
    case (state_next)
      TX_START: tx_next = LINE_START;
      TX_DATA:  tx_next = shift_next[0];
      TX_STOP:  tx_next = LINE_STOP;
      default:  tx_next = LINE_IDLE;
    endcase
  end

  assign ACK_UTX = ack_reg;
  assign DAT_UTX = rd_data_reg;
  assign TxD     = tx_reg;
  assign IntTx   = int_reg;

endmodule

// File: doc/wb_uart_tx.md
# wb_uart_tx

Wishbone-slave UART transmitter peripheral: accepts bytes from the processor through the 8-bit Wishbone interconnect, buffers them in a small FIFO and serialises them as 8N1 frames on a TxD line. It is the responder end of the bridge → Wishbone → device path and raises one hardware-interrupt line (into HWInt) when its transmit path has drained. It sits beside the existing UART and timer devices on the same interconnect.

## Interface
- CLK_DIV, 434: PClk cycles per serial bit (434 = 50 MHz / 115200); ≥ 2.
- FIFO_DEPTH, 4: transmit FIFO entries; power of two, ≥ 2.

- PClk  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- ADR_WB  in  5  word address [6:2]; only ADR_WB[3:2] decoded, upper bits ignored.
- DAT_WB  in  8  write data.
- WE_WB  in  1  1 = write, 0 = read.
- STB_UTX  in  1  strobe (chip select) from the interconnect.
- ACK_UTX  out  1  single-cycle acknowledge.
- DAT_UTX  out  8  read data, valid while ACK_UTX = 1.
- TxD  out  1  serial output, idle high.
- IntTx  out  1  level interrupt request.

## Operation
- Register map (ADR_WB[3:2]):
  - 0 TXDATA: write pushes DAT_WB into FIFO; read returns 0x00.
  - 1 STATUS (read-only): bit0 busy (FSM ≠ IDLE), bit1 FIFO full, bit2 FIFO empty, bit3 IE, bit4 overflow (sticky); bits 7:5 = 0. Reading clears overflow. Writes ignored.
  - 2 CTRL: bit0 IE, read/write; other bits read 0.
  - 3 reserved: reads 0x00, writes ignored.
- Access accepted at a rising edge with STB_UTX = 1 and ACK_UTX = 0; side effects (push, CTRL write, overflow clear) commit at that edge.
- Push when FIFO full (full judged before any same-edge pop): byte dropped, overflow set, access still acknowledged.
- Push and pop on the same edge: both take effect; count unchanged.
- Transmit FSM states IDLE → START → DATA → STOP:
  - IDLE: TxD = 1; if FIFO non-empty, pop into shift register → START.
  - START: TxD = 0 for CLK_DIV cycles → DATA.
  - DATA: 8 bits, LSB first, CLK_DIV cycles each; 3-bit bit counter → STOP after bit 7.
  - STOP: TxD = 1 for CLK_DIV cycles; at end, if FIFO non-empty pop and go directly to START, else → IDLE.
- Baud counter reloads CLK_DIV−1 on every state entry, counts down to 0; bit boundary at 0.
- IntTx = IE & FIFO empty & FSM in IDLE (registered).

## Timing
- Reset values: ACK_UTX = 0, DAT_UTX = 0x00, TxD = 1, IntTx = 0, IE = 0, overflow = 0, FIFO empty, FSM = IDLE, counters 0.
- ACK_UTX high exactly one cycle, the cycle after acceptance; STB_UTX held through ACK is not a second access; a new access needs STB_UTX sampled with ACK_UTX = 0.
- DAT_UTX registered at acceptance edge; returns 0x00 outside acknowledged reads.
- Push at edge N into empty FIFO with FSM IDLE → pop at edge N+1, TxD falls after edge N+1.
- Frame = 10·CLK_DIV cycles; back-to-back frames have no idle gap.
- Reset asserted mid-frame: TxD returns high the next edge, FIFO contents discarded, no partial bits resume.
- IntTx rises one cycle after FSM enters IDLE with FIFO empty and IE = 1; falls one cycle after a push or IE clear.

## Structure
- Shared package uart_pkg: register offsets (TXDATA, STATUS, CTRL), STATUS bit indices, FSM state enum, 8N1 frame constants.
- One sub-module: uart_tx_fifo (synchronous FIFO, push/pop/full/empty, width 8, depth FIFO_DEPTH). Register decode, FSM, baud/bit counters stay in wb_uart_tx.

## Test plan
- Reset, then idle 50 cycles → TxD = 1, ACK_UTX = 0, IntTx = 0, STATUS read = 0x04.
- CLK_DIV = 4; write 0xA5 to TXDATA → ACK one cycle later; TxD 0 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), stop 1; STATUS busy during frame.
- Write CTRL = 0x01, then bytes 0x00 and 0xFF back-to-back → two contiguous 40-cycle frames, no gap; IntTx rises 1 cycle after second stop bit ends.
- FIFO_DEPTH = 4; six writes while first frame shifts → fifth accepted, sixth dropped, STATUS bit4 = 1; second STATUS read shows bit4 = 0; exactly five frames emitted.
- STB_UTX held 3 cycles on a TXDATA write → single ACK pulse, single push.
- Assert Reset mid-DATA bit 3 → TxD = 1 next cycle, STATUS = 0x04 after release, no further frames.
